// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
// Lane 0 is the most significant byte (big-endian).
package dmem_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD,
        SIZE_ERR
    } size_e;

    localparam logic [LANES-1:0] WE_NONE = 4'b0000;
    localparam logic [LANES-1:0] WE_B0   = 4'b1000;
    localparam logic [LANES-1:0] WE_B1   = 4'b0100;
    localparam logic [LANES-1:0] WE_B2   = 4'b0010;
    localparam logic [LANES-1:0] WE_B3   = 4'b0001;
    localparam logic [LANES-1:0] WE_H0   = 4'b1100;
    localparam logic [LANES-1:0] WE_H2   = 4'b0011;
    localparam logic [LANES-1:0] WE_W    = 4'b1111;

    // Load context captured at grant time and used when read data returns.
    typedef struct packed {
        size_e      size;
        logic [1:0] offset;
        logic       is_signed;
    } ld_ctx_t;

    // byte and half both set is an illegal size.
    function automatic size_e size_decode(input logic is_byte, input logic is_half);
        case ({is_byte, is_half})
            2'b10:   return BYTE;
            2'b01:   return HALF;
            2'b00:   return WORD;
            default: return SIZE_ERR;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Requester (CPU, loader) and BRAM signals of the data-memory access controller.
// The controller uses the slave modport; requesters and the BRAM use master.
interface dmem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_byte;
    logic              cpu_half;
    logic              cpu_signed;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              cpu_misalign;

    logic              ldr_req;
    logic [ADDR_W-1:0] ldr_addr;
    logic [31:0]       ldr_wdata;
    logic              ldr_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wea;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_byte, cpu_half, cpu_signed, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_misalign,
        output ldr_req, ldr_addr, ldr_wdata,
        input  ldr_ack,
        input  mem_addr, mem_wea, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_byte, cpu_half, cpu_signed, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_misalign,
        input  ldr_req, ldr_addr, ldr_wdata,
        output ldr_ack,
        output mem_addr, mem_wea, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store enables/steering/misalign detection
// and load lane extraction with zero/sign extension.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  size_e             size,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] wdata,
    output logic [LANES-1:0]  wea_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic              misalign_c,
    input  ld_ctx_t           ld_ctx,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ld_data_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: replicate data into every lane so all lanes stay deterministic.
    always_comb begin
        wea_c      = WE_NONE;
        wdata_c    = wdata;
        misalign_c = 1'b0;
        case (size)
            BYTE: begin
                wdata_c = {4{wdata[7:0]}};
                case (offset)
                    2'd0:    wea_c = WE_B0;
                    2'd1:    wea_c = WE_B1;
                    2'd2:    wea_c = WE_B2;
                    default: wea_c = WE_B3;
                endcase
            end
            HALF: begin
                wdata_c = {2{wdata[15:0]}};
                if (offset[0]) begin
                    misalign_c = 1'b1;
                end else begin
                    wea_c = offset[1] ? WE_H2 : WE_H0;
                end
            end
            WORD: begin
                if (offset != 2'd0) begin
                    misalign_c = 1'b1;
                end else begin
                    wea_c = WE_W;
                end
            end
            default: misalign_c = 1'b1;
        endcase
    end

    // Load side: offset 0 is bits 31:24.
    always_comb begin
        ld_byte   = rdata[31:24];
        ld_half   = rdata[31:16];
        ld_data_c = rdata;
        case (ld_ctx.offset)
            2'd1:    ld_byte = rdata[23:16];
            2'd2:    ld_byte = rdata[15:8];
            2'd3:    ld_byte = rdata[7:0];
            default: ld_byte = rdata[31:24];
        endcase
        if (ld_ctx.offset[1]) begin
            ld_half = rdata[15:0];
        end
        case (ld_ctx.size)
            BYTE:    ld_data_c = {{24{ld_ctx.is_signed & ld_byte[7]}}, ld_byte};
            HALF:    ld_data_c = {{16{ld_ctx.is_signed & ld_half[15]}}, ld_half};
            default: ld_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: loader/CPU arbitration, BRAM issue with
// 1-cycle read latency, load alignment and one-cycle completion pulses.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    dmem_access_ctrl_if.slave bus
);

    state_e            state;
    logic              grant_ldr;
    logic              store_q;
    ld_ctx_t           ld_ctx;

    size_e             req_size_c;
    logic [LANES-1:0]  wea_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] ld_data_c;
    logic              misalign_c;
    logic              unused_ldr_offset_c;

    assign req_size_c          = size_decode(bus.cpu_byte, bus.cpu_half);
    assign unused_ldr_offset_c = ^bus.ldr_addr[1:0];

    dmem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .size       (req_size_c),
        .offset     (bus.cpu_addr[1:0]),
        .wdata      (bus.cpu_wdata),
        .wea_c      (wea_c),
        .wdata_c    (wdata_c),
        .misalign_c (misalign_c),
        .ld_ctx     (ld_ctx),
        .rdata      (bus.mem_rdata),
        .ld_data_c  (ld_data_c)
    );

    // Grant is decided only in IDLE and held until DONE; pulses default low.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            grant_ldr        <= 1'b0;
            store_q          <= 1'b0;
            ld_ctx           <= '0;
            bus.mem_addr     <= '0;
            bus.mem_wea      <= WE_NONE;
            bus.mem_wdata    <= '0;
            bus.cpu_rdata    <= '0;
            bus.cpu_ready    <= 1'b0;
            bus.cpu_misalign <= 1'b0;
            bus.ldr_ack      <= 1'b0;
        end else begin
            bus.mem_wea      <= WE_NONE;
            bus.cpu_ready    <= 1'b0;
            bus.cpu_misalign <= 1'b0;
            bus.ldr_ack      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ldr_req) begin
                        grant_ldr     <= 1'b1;
                        store_q       <= 1'b1;
                        bus.mem_addr  <= {bus.ldr_addr[ADDR_W-1:2], 2'b00};
                        bus.mem_wea   <= WE_W;
                        bus.mem_wdata <= bus.ldr_wdata;
                        state         <= ISSUE;
                    end else if (bus.cpu_req) begin
                        grant_ldr <= 1'b0;
                        store_q   <= bus.cpu_we;
                        ld_ctx    <= '{size: req_size_c, offset: bus.cpu_addr[1:0],
                                       is_signed: bus.cpu_signed};
                        if (misalign_c) begin
                            bus.cpu_rdata    <= '0;
                            bus.cpu_ready    <= 1'b1;
                            bus.cpu_misalign <= 1'b1;
                            state            <= DONE;
                        end else begin
                            bus.mem_addr  <= {bus.cpu_addr[ADDR_W-1:2], 2'b00};
                            bus.mem_wea   <= bus.cpu_we ? wea_c : WE_NONE;
                            bus.mem_wdata <= wdata_c;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (store_q) begin
                        bus.ldr_ack   <= grant_ldr;
                        bus.cpu_ready <= ~grant_ldr;
                        state         <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    bus.cpu_rdata <= ld_data_c;
                    bus.cpu_ready <= 1'b1;
                    state         <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
